cv32e40p_fetch_aligner: RTL and testbench

Instruction aligner between the prefetch buffer and the ID stage. It consumes 32-bit words from the prefetch buffer's fetch handshake and reassembles them into whole RV32IC instructions. It handles compressed instructions and 32-bit instructions that straddle a word boundary, and tracks the PC of each delivered instruction. On a branch it resynchronises, including to halfword-aligned targets.

---
 rtl/cv32e40p_fetch_aligner_if.sv | 21 ++
 rtl/cv32e40p_fetch_aligner.sv | 60 ++++++
 tb/tb_cv32e40p_fetch_aligner.sv | 97 +++++++++
 3 files changed

// File: rtl/cv32e40p_fetch_aligner_if.sv
// cv32e40p_fetch_aligner_if: fetch-side handshake, branch redirect and aligned-instruction bus of the aligner.
interface cv32e40p_fetch_aligner_if;
    logic        fetch_valid_i;
    logic [31:0] fetch_rdata_i;
    logic        fetch_ready_o;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        instr_valid_o;
    logic [31:0] instr_aligned_o;
    logic        instr_compressed_o;
    logic [31:0] pc_o;
    logic        id_ready_i;
    modport slave (
        input  fetch_valid_i, fetch_rdata_i, branch_i, branch_addr_i, id_ready_i,
        output fetch_ready_o, instr_valid_o, instr_aligned_o, instr_compressed_o, pc_o
    );
    modport master (
        output fetch_valid_i, fetch_rdata_i, branch_i, branch_addr_i, id_ready_i,
        input  fetch_ready_o, instr_valid_o, instr_aligned_o, instr_compressed_o, pc_o
    );
endinterface

// File: rtl/cv32e40p_fetch_aligner.sv
// cv32e40p_fetch_aligner: reassembles RV32IC instructions from 32-bit prefetch words and tracks their PC.
module cv32e40p_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                        clk,
    input logic                        rst,
    cv32e40p_fetch_aligner_if.slave    bus
);
    typedef enum logic [1:0] {ALIGNED, MISALIGNED, BRANCH_SKIP} state_t;
    state_t      state_q;
    logic [31:0] pc_q;
    logic [15:0] hold_q;
    logic        hold_c, word_c, live, valid, accept, ready;
    logic [31:0] instr;
    always_comb begin
        hold_c = hold_q[1:0] != 2'b11;
        word_c = bus.fetch_rdata_i[1:0] != 2'b11;
        live   = !rst && !bus.branch_i;
        valid  = live && (state_q == ALIGNED    ? bus.fetch_valid_i :
                          state_q == MISALIGNED ? (hold_c || bus.fetch_valid_i) : 1'b0);
        instr  = state_q == MISALIGNED ? (hold_c ? {16'h0, hold_q} : {bus.fetch_rdata_i[15:0], hold_q})
                                       : (word_c ? {16'h0, bus.fetch_rdata_i[15:0]} : bus.fetch_rdata_i);
        accept = valid && bus.id_ready_i;
        // A compressed hold_q drains on its own; the current word stays with the prefetcher
        ready  = state_q == BRANCH_SKIP ? live && bus.fetch_valid_i
                                        : accept && !(state_q == MISALIGNED && hold_c);
    end
    assign bus.instr_valid_o      = valid;
    assign bus.instr_aligned_o    = instr;
    assign bus.instr_compressed_o = instr[1:0] != 2'b11;
    assign bus.fetch_ready_o      = ready;
    assign bus.pc_o               = pc_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ALIGNED;
            pc_q    <= RESET_PC;
            hold_q  <= 16'h0;
        end else if (bus.branch_i) begin
            pc_q    <= bus.branch_addr_i & ~32'h1;
            state_q <= bus.branch_addr_i[1] ? BRANCH_SKIP : ALIGNED;
        end else if (state_q == BRANCH_SKIP) begin
            if (bus.fetch_valid_i) begin
                hold_q  <= bus.fetch_rdata_i[31:16];
                state_q <= MISALIGNED;
            end
        end else if (accept) begin
            if (state_q == ALIGNED && word_c) begin
                hold_q  <= bus.fetch_rdata_i[31:16];
                pc_q    <= pc_q + 32'd2;
                state_q <= MISALIGNED;
            end else if (state_q == MISALIGNED && hold_c) begin
                pc_q    <= pc_q + 32'd2;
                state_q <= ALIGNED;
            end else begin
                pc_q <= pc_q + 32'd4;
                if (state_q == MISALIGNED) hold_q <= bus.fetch_rdata_i[31:16];
            end
        end
    end
endmodule

// File: tb/tb_cv32e40p_fetch_aligner.sv
// tb_cv32e40p_fetch_aligner: random fetch/branch/stall traffic over a halfword program image, checked against an instruction-stream model.
module tb_cv32e40p_fetch_aligner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   accepts = 0;
    logic [15:0] mem [0:1023];
    logic [31:0] mpc, fa, tgt, exp_instr;
    logic        skip, fv, idr, br, exp_valid, exp_ready;
    int          len;
    cv32e40p_fetch_aligner_if bus ();
    cv32e40p_fetch_aligner #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (mpc=%h fa=%h)", tag, got, exp, mpc, fa);
        end
    endtask
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem[((a >> 1) + 1) & 1023], mem[(a >> 1) & 1023]};
    endfunction
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        {mem[65], mem[64]} = 32'h00A00093;
        {mem[67], mem[66]} = 32'h00934505;
        {mem[69], mem[68]} = 32'h450500A0;
        {mem[129], mem[128]} = 32'h4505ABCD;
        bus.fetch_valid_i = 1'b1;
        bus.fetch_rdata_i = 32'h00A00093;
        bus.branch_i      = 1'b0;
        bus.branch_addr_i = 32'h0;
        bus.id_ready_i    = 1'b1;
        #1;
        check("reset_valid", {31'h0, bus.instr_valid_o}, 32'h0);
        check("reset_ready", {31'h0, bus.fetch_ready_o}, 32'h0);
        check("reset_pc", bus.pc_o, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        mpc  = 32'h0;
        fa   = 32'h0;
        skip = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            fv  = ($urandom_range(0, 3) != 0);
            idr = ($urandom_range(0, 3) != 0);
            br  = cyc == 0 || cyc == 40 || mpc > 32'd1900 || $urandom_range(0, 15) == 0;
            tgt = cyc == 0 ? 32'h80 : cyc == 40 ? 32'h102 : 32'($urandom_range(0, 900) * 2) | 32'($urandom_range(0, 1));
            bus.fetch_valid_i = fv;
            bus.fetch_rdata_i = fv ? word_at(fa) : $urandom;
            bus.id_ready_i    = idr;
            bus.branch_i      = br;
            bus.branch_addr_i = tgt;
            len       = mem[(mpc >> 1) & 1023][1:0] == 2'b11 ? 4 : 2;
            exp_instr = len == 4 ? word_at(mpc) : {16'h0, mem[(mpc >> 1) & 1023]};
            // The instruction is deliverable once every halfword it spans is already held or in the presented word
            exp_valid = !br && !skip && (mpc + len <= fa || (fv && mpc + len <= fa + 4));
            exp_ready = !br && (skip ? fv : exp_valid && idr && mpc + len > fa);
            #1;
            check("pc", bus.pc_o, mpc);
            check("valid", {31'h0, bus.instr_valid_o}, {31'h0, exp_valid});
            check("fetch_ready", {31'h0, bus.fetch_ready_o}, {31'h0, exp_ready});
            if (exp_valid) begin
                check("instr", bus.instr_aligned_o, exp_instr);
                check("compressed", {31'h0, bus.instr_compressed_o}, {31'h0, len == 2});
            end
            @(posedge clk);
            if (br) begin
                mpc  = tgt & ~32'h1;
                fa   = tgt & ~32'h3;
                skip = tgt[1];
            end else if (skip) begin
                if (fv) begin
                    fa   = fa + 4;
                    skip = 1'b0;
                end
            end else if (exp_valid && idr) begin
                accepts++;
                if (exp_ready) fa = fa + 4;
                mpc = mpc + 32'(len);
            end
            @(negedge clk);
        end
        check("progress", {31'h0, accepts > 500}, 32'h1);
        bus.fetch_valid_i = 1'b1;
        bus.branch_i      = 1'b0;
        bus.id_ready_i    = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'h0, bus.instr_valid_o}, 32'h0);
        check("midrst_ready", {31'h0, bus.fetch_ready_o}, 32'h0);
        check("midrst_pc", bus.pc_o, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
